// File: rtl/skid_buf.sv
// skid_buf: two-entry skid buffer placed in front of the instruction fifo.
// Registers in_ready so out_ready never reaches it combinationally.
// Optional feature macro: SKID_BUF_FLUSH_EN adds a 'flush' input that
// empties the buffer (state only; data registers keep their contents).
//
// state | meaning
// EMPTY | no entries held; out_valid low
// BUSY  | main holds the presented payload
// FULL  | main presented, skid holds the next payload; in_ready low
module skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  output logic             in_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef SKID_BUF_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  // Handshake outputs come straight from the state flops.
`ifdef SKID_BUF_FLUSH_EN
  assign in_ready  = (state_q != FULL) && !flush;
`else
  assign in_ready  = (state_q != FULL);
`endif
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Occupancy decode for debug visibility.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and data-register update; registers only move on a fire.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
`ifdef SKID_BUF_FLUSH_EN
    // Flush wins over every transition and leaves the payload registers alone.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
`endif
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_buf.sv
module tb_skid_buf;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_aL;
  logic             in_ready;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef SKID_BUF_FLUSH_EN
  logic             flush;
`endif

  int checks = 0;
  int errors = 0;

  skid_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef SKID_BUF_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_aL    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef SKID_BUF_FLUSH_EN
    flush     = 1'b0;
`endif
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_occ", {30'd0, occupancy}, 32'd0);
    check("rst_out_data", out_data, 32'd0);

    // Streaming with out_ready high: one per cycle, occupancy stays 1.
    rst_aL = 1'b1; in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
    tick();
    check("stream_a_data", out_data, 32'hA);
    check("stream_a_occ", {30'd0, occupancy}, 32'd1);
    check("stream_a_rdy", {31'd0, in_ready}, 32'd1);
    in_data = 32'hB;
    tick();
    check("stream_b_data", out_data, 32'hB);
    check("stream_b_occ", {30'd0, occupancy}, 32'd1);
    check("stream_b_rdy", {31'd0, in_ready}, 32'd1);
    in_data = 32'hC;
    tick();
    check("stream_c_data", out_data, 32'hC);
    check("stream_c_occ", {30'd0, occupancy}, 32'd1);
    check("stream_c_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", {31'd0, out_valid}, 32'd0);
    check("stream_drain_occ", {30'd0, occupancy}, 32'd0);

    // Backpressure: fill to FULL, third push refused, drain in order.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    check("bp_11_occ", {30'd0, occupancy}, 32'd1);
    check("bp_11_data", out_data, 32'h11);
    in_data = 32'h22;
    tick();
    check("bp_full_occ", {30'd0, occupancy}, 32'd2);
    check("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    check("bp_full_data", out_data, 32'h11);
    in_data = 32'h33;
    tick();
    check("bp_33_refused_occ", {30'd0, occupancy}, 32'd2);
    check("bp_33_refused_data", out_data, 32'h11);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_drain_22", out_data, 32'h22);
    check("bp_drain_22_occ", {30'd0, occupancy}, 32'd1);
    tick();
    check("bp_drain_empty", {31'd0, out_valid}, 32'd0);

    // From FULL, drain and push together: push waits one cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    check("f2_full_occ", {30'd0, occupancy}, 32'd2);
    out_ready = 1'b1; in_data = 32'h33;
    #1;
    check("f2_refuse_rdy", {31'd0, in_ready}, 32'd0);
    check("f2_head_11", out_data, 32'h11);
    tick();
    check("f2_head_22", out_data, 32'h22);
    check("f2_busy_occ", {30'd0, occupancy}, 32'd1);
    check("f2_accept_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check("f2_head_33", out_data, 32'h33);
    check("f2_33_occ", {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("f2_empty", {31'd0, out_valid}, 32'd0);

    // BUSY with simultaneous in_fire and out_fire stays BUSY.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
    tick();
    check("sim_5", out_data, 32'h5);
    in_data = 32'h6; out_ready = 1'b1;
    tick();
    check("sim_6_data", out_data, 32'h6);
    check("sim_6_occ", {30'd0, occupancy}, 32'd1);
    check("sim_6_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("sim_empty", {30'd0, occupancy}, 32'd0);

    // Asynchronous reset from FULL, mid-cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_data = 32'h88;
    tick();
    check("ar_full_occ", {30'd0, occupancy}, 32'd2);
    #2;
    rst_aL = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_occ", {30'd0, occupancy}, 32'd0);
    check("ar_rdy", {31'd0, in_ready}, 32'd1);
    check("ar_data", out_data, 32'd0);
    in_data = 32'h44;
    tick();
    check("ar_hold_occ", {30'd0, occupancy}, 32'd0);
    check("ar_hold_data", out_data, 32'd0);
    rst_aL = 1'b1; in_data = 32'h99;
    tick();
    check("ar_first_edge_data", out_data, 32'h99);
    check("ar_first_edge_occ", {30'd0, occupancy}, 32'd1);

`ifdef SKID_BUF_FLUSH_EN
    // Flush from FULL with a pending push.
    in_data = 32'hAA;
    tick();
    check("fl_full_occ", {30'd0, occupancy}, 32'd2);
    flush = 1'b1; in_data = 32'hBB;
    #1;
    check("fl_rdy", {31'd0, in_ready}, 32'd0);
    check("fl_valid_kept", {31'd0, out_valid}, 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occ", {30'd0, occupancy}, 32'd0);
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 32'hCC;
    tick();
    check("fl_after_data", out_data, 32'hCC);
    check("fl_after_occ", {30'd0, occupancy}, 32'd1);
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("final_empty", {30'd0, occupancy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
